// File: rtl/pcie_polling_substate.sv
// LTSSM Polling sub-state machine: Polling.Active (TS1) then Polling.Configuration (TS2).
// Each entry from Detect ends in exactly one registered exit pulse: success, compliance or timeout.
module pcie_polling_substate #(
  parameter int ACTIVE_TX_MIN  = 1024,
  parameter int RX_CONSEC      = 8,
  parameter int CFG_TX_MIN     = 16,
  parameter int ACTIVE_TMO_CYC = 24000,
  parameter int CFG_TMO_CYC    = 48000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       tx_os_done_i,
  input  logic       rx_os_valid_i,
  input  logic [1:0] rx_os_type_i,
  input  logic       rx_compliance_i,
  output logic       tx_os_req_o,
  output logic       tx_os_type_o,
  output logic [1:0] state_o,
  output logic       polling_done_o,
  output logic       to_compliance_o,
  output logic       to_detect_o
);

  localparam int TX_MAX  = (ACTIVE_TX_MIN > CFG_TX_MIN) ? ACTIVE_TX_MIN : CFG_TX_MIN;
  localparam int TMO_MAX = (ACTIVE_TMO_CYC > CFG_TMO_CYC) ? ACTIVE_TMO_CYC : CFG_TMO_CYC;
  localparam int TX_W    = $clog2(TX_MAX + 1);
  localparam int RX_W    = $clog2(RX_CONSEC + 1);
  localparam int TMR_W   = $clog2(TMO_MAX + 1);

  localparam logic [TX_W-1:0]  ACT_TX_LIM   = TX_W'(ACTIVE_TX_MIN);
  localparam logic [TX_W-1:0]  CFG_TX_LIM   = TX_W'(CFG_TX_MIN);
  localparam logic [RX_W-1:0]  RX_LIM       = RX_W'(RX_CONSEC);
  localparam logic [TMR_W-1:0] TMR_LIM      = TMR_W'(TMO_MAX);
  localparam logic [TMR_W-1:0] ACT_TMO_LAST = TMR_W'(ACTIVE_TMO_CYC - 1);
  localparam logic [TMR_W-1:0] CFG_TMO_LAST = TMR_W'(CFG_TMO_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_CONFIG = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [TX_W-1:0]  tx_cnt_q, tx_cnt_upd_s;
  logic [RX_W-1:0]  ok_cnt_q, ok_cnt_upd_s;
  logic [RX_W-1:0]  cmp_cnt_q, cmp_cnt_upd_s;
  logic [TMR_W-1:0] timer_q, timer_upd_s;
  logic             ts2_seen_q, ts2_seen_upd_s;
  logic             tx_req_q, tx_req_d, tx_type_q, tx_type_d;
  logic             done_q, done_d, cmp_q, cmp_d, det_q, det_d;
  logic             rx_ts1_s, rx_ts2_s, succ_s, compl_s, tmo_s;

  assign rx_ts1_s = rx_os_valid_i && (rx_os_type_i == 2'b01);
  assign rx_ts2_s = rx_os_valid_i && (rx_os_type_i == 2'b10);

  // Per-state counter updates; this cycle's events already count toward the exit check.
  always_comb begin
    tx_cnt_upd_s   = tx_cnt_q;
    ok_cnt_upd_s   = ok_cnt_q;
    cmp_cnt_upd_s  = cmp_cnt_q;
    timer_upd_s    = timer_q;
    ts2_seen_upd_s = ts2_seen_q;
    case (state_q)
      ST_ACTIVE: begin
        if (tx_os_done_i && (tx_cnt_q != ACT_TX_LIM)) tx_cnt_upd_s = tx_cnt_q + TX_W'(1);
        else tx_cnt_upd_s = tx_cnt_q;
        if (!rx_os_valid_i) begin
          ok_cnt_upd_s  = ok_cnt_q;
          cmp_cnt_upd_s = cmp_cnt_q;
        end else begin
          if ((rx_ts1_s || rx_ts2_s) && !rx_compliance_i)
            ok_cnt_upd_s = (ok_cnt_q == RX_LIM) ? RX_LIM : ok_cnt_q + RX_W'(1);
          else ok_cnt_upd_s = {RX_W{1'b0}};
          if (rx_ts1_s && rx_compliance_i)
            cmp_cnt_upd_s = (cmp_cnt_q == RX_LIM) ? RX_LIM : cmp_cnt_q + RX_W'(1);
          else cmp_cnt_upd_s = {RX_W{1'b0}};
        end
        timer_upd_s = (timer_q == TMR_LIM) ? TMR_LIM : timer_q + TMR_W'(1);
      end
      ST_CONFIG: begin
        // A completion in the same cycle as the first TS2 already counts.
        ts2_seen_upd_s = ts2_seen_q || rx_ts2_s;
        if (tx_os_done_i && ts2_seen_upd_s && (tx_cnt_q != CFG_TX_LIM)) tx_cnt_upd_s = tx_cnt_q + TX_W'(1);
        else tx_cnt_upd_s = tx_cnt_q;
        if (!rx_os_valid_i) ok_cnt_upd_s = ok_cnt_q;
        else if (rx_ts2_s) ok_cnt_upd_s = (ok_cnt_q == RX_LIM) ? RX_LIM : ok_cnt_q + RX_W'(1);
        else ok_cnt_upd_s = {RX_W{1'b0}};
        timer_upd_s = (timer_q == TMR_LIM) ? TMR_LIM : timer_q + TMR_W'(1);
      end
      default: begin
        timer_upd_s = timer_q;
      end
    endcase
  end

  assign succ_s  = ((state_q == ST_ACTIVE) && (ok_cnt_upd_s == RX_LIM) && (tx_cnt_upd_s == ACT_TX_LIM)) ||
                   ((state_q == ST_CONFIG) && (ok_cnt_upd_s == RX_LIM) && (tx_cnt_upd_s >= CFG_TX_LIM));
  assign compl_s = (state_q == ST_ACTIVE) && (cmp_cnt_upd_s == RX_LIM);
  assign tmo_s   = ((state_q == ST_ACTIVE) && (timer_q == ACT_TMO_LAST)) ||
                   ((state_q == ST_CONFIG) && (timer_q == CFG_TMO_LAST));

  // Next-state selection with exit priority success > compliance > timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_ACTIVE;
        else state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (succ_s) state_d = ST_CONFIG;
        else if (compl_s || tmo_s) state_d = ST_IDLE;
        else state_d = ST_ACTIVE;
      end
      ST_CONFIG: begin
        if (succ_s || tmo_s) state_d = ST_IDLE;
        else state_d = ST_CONFIG;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values: levels follow the next state, pulses mark the exit taken.
  always_comb begin
    tx_req_d  = (state_d != ST_IDLE);
    tx_type_d = (state_d == ST_CONFIG);
    done_d    = (state_q == ST_CONFIG) && succ_s;
    cmp_d     = (state_q == ST_ACTIVE) && !succ_s && compl_s;
    det_d     = (state_q != ST_IDLE) && !succ_s && !compl_s && tmo_s;
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      tx_req_q  <= 1'b0;
      tx_type_q <= 1'b0;
      done_q    <= 1'b0;
      cmp_q     <= 1'b0;
      det_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_req_q  <= tx_req_d;
      tx_type_q <= tx_type_d;
      done_q    <= done_d;
      cmp_q     <= cmp_d;
      det_q     <= det_d;
    end
  end

  // Counters restart from zero on every state change (entry into ACTIVE, CONFIG or IDLE).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_cnt_q   <= {TX_W{1'b0}};
      ok_cnt_q   <= {RX_W{1'b0}};
      cmp_cnt_q  <= {RX_W{1'b0}};
      timer_q    <= {TMR_W{1'b0}};
      ts2_seen_q <= 1'b0;
    end else if (state_d != state_q) begin
      tx_cnt_q   <= {TX_W{1'b0}};
      ok_cnt_q   <= {RX_W{1'b0}};
      cmp_cnt_q  <= {RX_W{1'b0}};
      timer_q    <= {TMR_W{1'b0}};
      ts2_seen_q <= 1'b0;
    end else begin
      tx_cnt_q   <= tx_cnt_upd_s;
      ok_cnt_q   <= ok_cnt_upd_s;
      cmp_cnt_q  <= cmp_cnt_upd_s;
      timer_q    <= timer_upd_s;
      ts2_seen_q <= ts2_seen_upd_s;
    end
  end

  assign state_o         = state_q;
  assign tx_os_req_o     = tx_req_q;
  assign tx_os_type_o    = tx_type_q;
  assign polling_done_o  = done_q;
  assign to_compliance_o = cmp_q;
  assign to_detect_o     = det_q;

endmodule

// File: tb/tb_pcie_polling_substate.sv
// Bench for pcie_polling_substate: vector table, directed corner sequences and
// random traffic checked cycle by cycle against a history-based reference model.
module tb_pcie_polling_substate;
  localparam int P_ACT_TX  = 20;
  localparam int P_RX      = 8;
  localparam int P_CFG_TX  = 16;
  localparam int P_ACT_TMO = 300;
  localparam int P_CFG_TMO = 400;

  logic       clk, rst_n;
  logic       start, tx_done, rx_valid, rx_cmp;
  logic [1:0] rx_type;
  logic       tx_req, tx_type, done_o, cmp_o, det_o;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  pcie_polling_substate #(
    .ACTIVE_TX_MIN(P_ACT_TX), .RX_CONSEC(P_RX), .CFG_TX_MIN(P_CFG_TX),
    .ACTIVE_TMO_CYC(P_ACT_TMO), .CFG_TMO_CYC(P_CFG_TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .tx_os_done_i(tx_done),
    .rx_os_valid_i(rx_valid), .rx_os_type_i(rx_type), .rx_compliance_i(rx_cmp),
    .tx_os_req_o(tx_req), .tx_os_type_o(tx_type), .state_o(state),
    .polling_done_o(done_o), .to_compliance_o(cmp_o), .to_detect_o(det_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 active, 2 config; last received sets kept in a queue.
  int m_mode, m_tx, m_cyc;
  bit m_seen, m_done, m_cmpx, m_det;
  int m_hist[$];

  // kind 0: TS1/TS2 without compliance, 1: TS1 with compliance, 2: TS2
  function automatic bit tail_all(input int kind);
    int t;
    bit c;
    if (m_hist.size() < P_RX) return 1'b0;
    for (int i = 0; i < m_hist.size(); i++) begin
      t = m_hist[i] / 2;
      c = (m_hist[i] % 2) == 1;
      if (kind == 0 && !((t == 1 || t == 2) && !c)) return 1'b0;
      if (kind == 1 && !(t == 1 && c)) return 1'b0;
      if (kind == 2 && t != 2) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_entry();
    m_tx = 0; m_cyc = 0; m_seen = 1'b0; m_hist.delete();
  endtask

  task automatic model_reset();
    m_mode = 0; m_done = 1'b0; m_cmpx = 1'b0; m_det = 1'b0;
    model_entry();
  endtask

  task automatic model_push(input logic [1:0] ty, input bit cp);
    m_hist.push_back(int'(ty) * 2 + int'(cp));
    if (m_hist.size() > P_RX) void'(m_hist.pop_front());
  endtask

  task automatic model_update(input bit st, input bit dn, input bit vl, input logic [1:0] ty, input bit cp);
    m_done = 1'b0; m_cmpx = 1'b0; m_det = 1'b0;
    case (m_mode)
      0: if (st) begin m_mode = 1; model_entry(); end
      1: begin
        if (vl) model_push(ty, cp);
        if (dn) m_tx++;
        if (tail_all(0) && m_tx >= P_ACT_TX) begin m_mode = 2; model_entry(); end
        else if (tail_all(1)) begin m_mode = 0; m_cmpx = 1'b1; end
        else if (m_cyc == P_ACT_TMO - 1) begin m_mode = 0; m_det = 1'b1; end
        else m_cyc++;
      end
      2: begin
        if (vl && ty == 2'b10) m_seen = 1'b1;
        if (vl) model_push(ty, cp);
        if (m_seen && dn) m_tx++;
        if (tail_all(2) && m_tx >= P_CFG_TX) begin m_mode = 0; m_done = 1'b1; end
        else if (m_cyc == P_CFG_TMO - 1) begin m_mode = 0; m_det = 1'b1; end
        else m_cyc++;
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cycle(input bit st, input bit dn, input bit vl, input logic [1:0] ty, input bit cp);
    start = st; tx_done = dn; rx_valid = vl; rx_type = ty; rx_cmp = cp;
    @(posedge clk);
    model_update(st, dn, vl, ty, cp);
    #1;
  endtask

  task automatic compare_model();
    check("state", int'(state), m_mode);
    check("tx_req", int'(tx_req), int'(m_mode != 0));
    check("tx_type", int'(tx_type), int'(m_mode == 2));
    check("polling_done", int'(done_o), int'(m_done));
    check("to_compliance", int'(cmp_o), int'(m_cmpx));
    check("to_detect", int'(det_o), int'(m_det));
  endtask

  task automatic step(input bit st, input bit dn, input bit vl, input logic [1:0] ty, input bit cp);
    drive_cycle(st, dn, vl, ty, cp);
    compare_model();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_req"}, int'(tx_req), 0);
    check({tag, "_type"}, int'(tx_type), 0);
    check({tag, "_pulses"}, int'({done_o, cmp_o, det_o}), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; tx_done = 1'b0; rx_valid = 1'b0; rx_type = 2'b00; rx_cmp = 1'b0;
    @(posedge clk); #1;
    check_all_zero("rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic enter_config();
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < P_ACT_TX; i++) step(1'b0, 1'b1, i >= P_ACT_TX - P_RX, 2'b01, 1'b0);
  endtask

  typedef struct {
    bit st, dn, vl; logic [1:0] ty; bit cp;
    int e_state; bit e_req, e_type, e_done, e_cmp, e_det;
  } vec_t;

  function automatic vec_t mk(input bit st, input bit dn, input bit vl, input logic [1:0] ty, input bit cp,
                              input int es, input bit er, input bit et, input bit ed, input bit ec, input bit ex);
    vec_t v;
    v.st = st; v.dn = dn; v.vl = vl; v.ty = ty; v.cp = cp;
    v.e_state = es; v.e_req = er; v.e_type = et; v.e_done = ed; v.e_cmp = ec; v.e_det = ex;
    return v;
  endfunction

  initial begin
    vec_t tbl[14];
    int   hit, dcnt, r;
    logic [1:0] ty;

    tbl[0] = mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) tbl[i] = mk(1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    model_reset();
    do_reset();

    // Vector table: compliance exit, idle behaviour, start ignored while active
    for (int i = 0; i < 14; i++) begin
      drive_cycle(tbl[i].st, tbl[i].dn, tbl[i].vl, tbl[i].ty, tbl[i].cp);
      check($sformatf("tbl%0d_state", i), int'(state), tbl[i].e_state);
      check($sformatf("tbl%0d_req", i), int'(tx_req), int'(tbl[i].e_req));
      check($sformatf("tbl%0d_type", i), int'(tx_type), int'(tbl[i].e_type));
      check($sformatf("tbl%0d_done", i), int'(done_o), int'(tbl[i].e_done));
      check($sformatf("tbl%0d_cmp", i), int'(cmp_o), int'(tbl[i].e_cmp));
      check($sformatf("tbl%0d_det", i), int'(det_o), int'(tbl[i].e_det));
    end

    // Full success path ACTIVE -> CONFIG -> polling_done
    do_reset();
    enter_config();
    check("t1_cfg_state", int'(state), 2);
    check("t1_cfg_ts2", int'(tx_type), 1);
    dcnt = 0;
    for (int i = 0; i < P_CFG_TX; i++) begin
      step(1'b0, 1'b1, i < P_RX, 2'b10, 1'b0);
      dcnt += int'(done_o);
    end
    check("t1_done_pulse", int'(done_o), 1);
    check("t1_idle_state", int'(state), 0);
    for (int i = 0; i < 3; i++) begin step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0); dcnt += int'(done_o); end
    check("t1_done_once", dcnt, 1);

    // Interrupted TS1 run restarts the consecutive count
    do_reset();
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < P_ACT_TX; i++) step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1, (i == 7) ? 2'b00 : 2'b01, 1'b0);
    check("t2_still_active", int'(state), 1);
    step(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    check("t2_to_config", int'(state), 2);

    // ACTIVE timeout latency, then CONFIG timeout latency
    do_reset();
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    hit = -1;
    for (int k = 1; k <= P_ACT_TMO + 5 && hit < 0; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
      if (det_o) hit = k;
    end
    check("t4_act_tmo_cycle", hit, P_ACT_TMO);
    enter_config();
    hit = -1;
    for (int k = 1; k <= P_CFG_TMO + 5 && hit < 0; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
      if (det_o) hit = k;
    end
    check("t4_cfg_tmo_cycle", hit, P_CFG_TMO);
    check("t4_cfg_tmo_idle", int'(state), 0);

    // Success on the timeout cycle wins
    do_reset();
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < P_ACT_TMO; i++) step(1'b0, i < P_ACT_TX, i >= P_ACT_TMO - P_RX, 2'b01, 1'b0);
    check("t5_succ_state", int'(state), 2);
    check("t5_succ_no_det", int'(det_o), 0);

    // Compliance on the timeout cycle beats timeout
    do_reset();
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < P_ACT_TMO; i++) step(1'b0, 1'b0, i >= P_ACT_TMO - P_RX, 2'b01, 1'b1);
    check("t5_cmp_pulse", int'(cmp_o), 1);
    check("t5_cmp_no_det", int'(det_o), 0);

    // Asynchronous reset mid-CONFIG, then a fresh entry starts from zero counts
    do_reset();
    enter_config();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t5_async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < P_ACT_TX - 1; i++) step(1'b0, 1'b1, i >= P_ACT_TX - 1 - P_RX, 2'b01, 1'b0);
    check("t5_restart_active", int'(state), 1);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    check("t5_restart_config", int'(state), 2);

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        r = int'($urandom_range(0, 99));
        if (m_mode == 2) ty = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
        else ty = (r < 10) ? 2'b00 : (r < 75) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
        step($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             ty, $urandom_range(0, 4) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
